// File: rtl/csel_divider8_pkg.sv
// ============================================================================
// Module   : csel_div_pkg
// Brief    : Shared FSM states and constants for the csel_divider8 datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csel_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C_DEF_WIDTH = 8;
    localparam int C_MAX_WIDTH = 16;
    localparam int C_CNT_W     = $clog2(C_DEF_WIDTH);

    // Widest supported all-ones quotient; users slice to their own WIDTH.
    localparam logic [C_MAX_WIDTH-1:0] C_DBZ_QUOT = '1;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csel_divider8_csel_sub9.sv
// ============================================================================
// Module   : csel_sub9
// Brief    : (WIDTH+1)-bit carry-select subtractor: RCA low block, then
//            RCA + binary-to-excess-1 + mux upper blocks. a - b, borrow out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_sub9 #(
    parameter int WIDTH = 8,
    parameter int BLK_W = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    localparam int N     = WIDTH + 1;
    localparam int LOW_W = (N < BLK_W) ? N : BLK_W;
    // One spare bit above N so the final carry lands in the padded sum.
    localparam int NBLK  = (N - LOW_W + BLK_W) / BLK_W;
    localparam int PADN  = LOW_W + NBLK * BLK_W;

    logic [PADN-1:0]             w_ap;
    logic [PADN-1:0]             w_bp;
    logic [PADN-1:0]             w_sum;
    logic [LOW_W-1:0]            w_slo;
    logic                        w_clo;
    logic [NBLK-1:0][BLK_W-1:0]  w_s0a;
    logic [NBLK-1:0][BLK_W-1:0]  w_s1a;
    logic [NBLK-1:0]             w_c0a;
    logic [NBLK-1:0]             w_c1a;

    assign w_ap = {{(PADN-N){1'b0}}, a};
    assign w_bp = {{(PADN-N){1'b0}}, ~b};

    // Low block: plain ripple with carry-in 1 completes the two's complement.
    always_comb begin
        logic c;
        c     = 1'b1;
        w_slo = '0;
        for (int i = 0; i < LOW_W; i++) begin
            w_slo[i] = w_ap[i] ^ w_bp[i] ^ c;
            c        = (w_ap[i] & w_bp[i]) | (c & (w_ap[i] ^ w_bp[i]));
        end
        w_clo = c;
    end

    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            localparam int LO = LOW_W + k * BLK_W;
            logic [BLK_W-1:0] w_s0;
            logic [BLK_W-1:0] w_s1;
            logic             w_c0;
            logic             w_c1;

            always_comb begin
                logic c;
                logic t;
                c    = 1'b0;
                t    = 1'b1;
                w_s0 = '0;
                w_s1 = '0;
                for (int j = 0; j < BLK_W; j++) begin
                    w_s0[j] = w_ap[LO+j] ^ w_bp[LO+j] ^ c;
                    c       = (w_ap[LO+j] & w_bp[LO+j]) | (c & (w_ap[LO+j] ^ w_bp[LO+j]));
                end
                for (int j = 0; j < BLK_W; j++) begin
                    w_s1[j] = w_s0[j] ^ t;
                    t       = t & w_s0[j];
                end
                w_c0 = c;
                w_c1 = c | t;
            end

            assign w_s0a[k] = w_s0;
            assign w_s1a[k] = w_s1;
            assign w_c0a[k] = w_c0;
            assign w_c1a[k] = w_c1;
        end
    endgenerate

    always_comb begin
        logic c;
        w_sum            = '0;
        w_sum[LOW_W-1:0] = w_slo;
        c                = w_clo;
        for (int k = 0; k < NBLK; k++) begin
            w_sum[LOW_W + k*BLK_W +: BLK_W] = c ? w_s1a[k] : w_s0a[k];
            c = c ? w_c1a[k] : w_c0a[k];
        end
    end

    assign diff   = w_sum[N-1:0];
    assign borrow = ~w_sum[N];

    generate
        if (PADN > N + 1) begin : g_spare
            logic [PADN-N-2:0] w_spare_unused;
            assign w_spare_unused = w_sum[PADN-1:N+1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/csel_divider8.sv
// ============================================================================
// Module   : csel_divider8
// Brief    : Sequential radix-2 restoring divider with valid/ready handshake.
//            Optional macro DIV_SIGNED_EN selects two's complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_divider8
    import csel_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int             CW         = cnt_w(WIDTH);
    localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] C_ZERO   = '0;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_qsh;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic             w_trial_msb_unused;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;
    logic             w_div_zero;

    csel_sub9 #(.WIDTH(WIDTH)) u_sub (
        .a      ({r_rem, r_qsh[WIDTH-1]}),
        .b      ({1'b0, r_dsr}),
        .diff   (w_trial),
        .borrow (w_borrow)
    );

    // A successful trial always leaves a remainder below the divisor, so
    // its top bit is zero; a failed trial implies the shift fits WIDTH bits.
    assign w_trial_msb_unused = w_trial[WIDTH];
    assign w_rem_nx   = w_borrow ? {r_rem[WIDTH-2:0], r_qsh[WIDTH-1]} : w_trial[WIDTH-1:0];
    assign w_q_nx     = {r_qsh[WIDTH-2:0], ~w_borrow};
    assign w_div_zero = (divisor == C_ZERO);

`ifdef DIV_SIGNED_EN
    logic r_qneg;
    logic r_rneg;

    assign w_abs_a = dividend[WIDTH-1] ? (C_ZERO - dividend) : dividend;
    assign w_abs_b = divisor[WIDTH-1]  ? (C_ZERO - divisor)  : divisor;
    assign w_q_fin = r_qneg ? (C_ZERO - w_q_nx)   : w_q_nx;
    assign w_r_fin = r_rneg ? (C_ZERO - w_rem_nx) : w_rem_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_rneg <= dividend[WIDTH-1];
        end
    end
`else
    assign w_abs_a = dividend;
    assign w_abs_b = divisor;
    assign w_q_fin = w_q_nx;
    assign w_r_fin = w_rem_nx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_qsh  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rem <= '0;
                        r_qsh <= w_abs_a;
                        r_dsr <= w_abs_b;
                        r_cnt <= C_CNT_INIT;
                        if (w_div_zero) begin
                            r_quot <= C_DBZ_QUOT[WIDTH-1:0];
                            r_remo <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nx;
                    r_qsh <= w_q_nx;
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (r_cnt == '0) begin
                        r_quot <= w_q_fin;
                        r_remo <= w_r_fin;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_remo;
    assign dbz       = r_dbz;

endmodule

`default_nettype wire
